// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed hex display driver (package seg_pkg).
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; leftmost entry is index 15 (F), rightmost is index 0.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg_scan_driver_hex7_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex7_decode
  import seg_pkg::*;
(
  input  digit_t      digit_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    seg_o = SEG_LUT[digit_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display scanner with guard interval and per-digit blink.
// Optional leading-zero blanking is compiled in with SEG_SCAN_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int SLOT_CYCLES  = 24000,
  parameter int GUARD_CYCLES = 16,
  parameter int BLINK_HALF   = 5000000
) (
  input  logic                    int_osc,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] vals,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    heartbeat
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [SW-1:0]           slot_q, slot_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_q, blink_d;
  logic                    hb_q, hb_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    slot_wrap, blink_wrap;
  digit_t                  cur_digit;
  logic [6:0]              dec_seg;

  // Outputs are built from next-state values so they line up with the counters they describe.
  always_comb begin
    slot_wrap  = (slot_q == SW'(SLOT_CYCLES - 1));
    slot_d     = slot_wrap ? '0 : slot_q + SW'(1);
    idx_d      = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    disp_d     = slot_wrap ? pend_q : disp_q;
    pend_d     = load ? vals : pend_q;
    blink_wrap = (blink_q == BW'(BLINK_HALF - 1));
    blink_d    = blink_wrap ? '0 : blink_q + BW'(1);
    hb_d       = hb_q ^ blink_wrap;

    cur_digit = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) cur_digit = disp_d[4*k +: 4];
    end

    anode_d = ANODE_OFF[NUM_DIGITS-1:0];
    if ((int'(slot_d) >= GUARD_CYCLES) && !(!hb_d && blink_mask[idx_d])) begin
      anode_d[idx_d] = 1'b0;
    end
  end

  hex7_decode u_dec (
    .digit_i (cur_digit),
    .seg_o   (dec_seg)
  );

`ifdef SEG_SCAN_LZB_EN
  logic upper_nz;
  logic lzb_blank;

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    upper_nz = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) >= idx_d) && (disp_d[4*k +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    lzb_blank = (idx_d != '0) && !upper_nz;
    seg_d     = lzb_blank ? SEG_OFF : dec_seg;
  end
`else
  always_comb begin
    seg_d = dec_seg;
  end
`endif

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      slot_q  <= '0;
      idx_q   <= '0;
      blink_q <= '0;
      hb_q    <= 1'b0;
      pend_q  <= '0;
      disp_q  <= '0;
      anode_q <= '1;
      seg_q   <= SEG_OFF;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      hb_q    <= hb_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode     = anode_q;
  assign seg       = seg_q;
  assign heartbeat = hb_q;

endmodule
